// File: rtl/matrix_alu_sched.sv
// Round-robin scheduler sharing one registered-latency matrix_alu between two requesters.
// Optional per-requester response counters are built when MATRIX_ALU_SCHED_PERF_EN is defined.
module matrix_alu_sched #(
    parameter int word_size     = 8,
    parameter int Amatrixrownum = 2,
    parameter int Amatrixcolnum = 2,
    parameter int Bmatrixrownum = 2,
    parameter int Bmatrixcolnum = 2
) (
    input  logic                                                                   clk,
    input  logic                                                                   resetn,
    input  logic                                                                   req0_valid,
    output logic                                                                   req0_ready,
    input  logic [1:0]                                                             req0_op,
    input  logic [Amatrixrownum*Amatrixcolnum*word_size-1:0]                       req0_A,
    input  logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0]                       req0_B,
    input  logic                                                                   req1_valid,
    output logic                                                                   req1_ready,
    input  logic [1:0]                                                             req1_op,
    input  logic [Amatrixrownum*Amatrixcolnum*word_size-1:0]                       req1_A,
    input  logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0]                       req1_B,
    output logic [1:0]                                                             alu_op,
    output logic [Amatrixrownum*Amatrixcolnum*word_size-1:0]                       alu_A,
    output logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0]                       alu_B,
    input  logic [Amatrixrownum*Amatrixcolnum*Bmatrixrownum*Bmatrixcolnum*word_size-1:0] alu_C,
    output logic                                                                   rsp_valid,
    input  logic                                                                   rsp_ready,
    output logic                                                                   rsp_id,
    output logic [Amatrixrownum*Amatrixcolnum*Bmatrixrownum*Bmatrixcolnum*word_size-1:0] rsp_C,
    output logic [31:0]                                                            perf_cnt0,
    output logic [31:0]                                                            perf_cnt1
);

    localparam int AW = Amatrixrownum * Amatrixcolnum * word_size;
    localparam int BW = Bmatrixrownum * Bmatrixcolnum * word_size;
    localparam int CW = Amatrixrownum * Amatrixcolnum * Bmatrixrownum * Bmatrixcolnum * word_size;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] a_q, a_d;
    logic [BW-1:0] b_q, b_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic [CW-1:0] rsp_c_q, rsp_c_d;

    logic grant;
    logic idle;
    logic cmd_hs;
    logic rsp_hs;

    // A lone requester always wins; on contention the one not served last time wins.
    always_comb begin
        grant = ~last_grant_q;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign idle       = (state_q == IDLE);
    assign req0_ready = idle && req0_valid && !grant;
    assign req1_ready = idle && req1_valid && grant;
    assign cmd_hs     = req0_ready || req1_ready;
    assign rsp_hs     = (state_q == RESP) && rsp_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_c_d      = rsp_c_q;
        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    op_d         = grant ? req1_op : req0_op;
                    a_d          = grant ? req1_A  : req0_A;
                    b_d          = grant ? req1_B  : req0_B;
                    rsp_id_d     = grant;
                    last_grant_d = grant;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                rsp_c_d     = alu_C;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_c_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_c_q      <= rsp_c_d;
        end
    end

    assign alu_op    = op_q;
    assign alu_A     = a_q;
    assign alu_B     = b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_C     = rsp_c_q;

`ifdef MATRIX_ALU_SCHED_PERF_EN
    logic [31:0] perf0_q, perf0_d;
    logic [31:0] perf1_q, perf1_d;

    always_comb begin
        perf0_d = perf0_q;
        perf1_d = perf1_q;
        if (rsp_hs) begin
            if (rsp_id_q) begin
                perf1_d = perf1_q + 32'd1;
            end else begin
                perf0_d = perf0_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf0_q <= '0;
            perf1_q <= '0;
        end else begin
            perf0_q <= perf0_d;
            perf1_q <= perf1_d;
        end
    end

    assign perf_cnt0 = perf0_q;
    assign perf_cnt1 = perf1_q;
`else
    assign perf_cnt0 = '0;
    assign perf_cnt1 = '0;
`endif

endmodule

// File: tb/tb_matrix_alu_sched.sv
// Self-checking bench for matrix_alu_sched: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a transaction-level reference model.
module tb_matrix_alu_sched;
    localparam int WS = 8;
    localparam int AR = 2;
    localparam int AC = 2;
    localparam int BR = 2;
    localparam int BC = 2;
    localparam int AW = AR * AC * WS;
    localparam int BW = BR * BC * WS;
    localparam int CW = AR * AC * BR * BC * WS;

    logic          clk = 1'b0;
    logic          resetn;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]    req0_op, req1_op, alu_op;
    logic [AW-1:0] req0_A, req1_A, alu_A;
    logic [BW-1:0] req0_B, req1_B, alu_B;
    logic [CW-1:0] alu_C, rsp_C;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [31:0]   perf_cnt0, perf_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          id;
        logic [1:0]    op;
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [CW-1:0] c;
    } vec_t;

    vec_t vecs [7];

    matrix_alu_sched #(
        .word_size(WS), .Amatrixrownum(AR), .Amatrixcolnum(AC),
        .Bmatrixrownum(BR), .Bmatrixcolnum(BC)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_A(req0_A), .req0_B(req0_B),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_A(req1_A), .req1_B(req1_B),
        .alu_op(alu_op), .alu_A(alu_A), .alu_B(alu_B), .alu_C(alu_C),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_C(rsp_C),
        .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
    );

    always #5 clk = ~clk;

    // Element (r,c) lives at index r*cols+c, element 0 in the least significant bits.
    function automatic logic [CW-1:0] alu_ref(input logic [1:0] op, input logic [AW-1:0] a,
                                              input logic [BW-1:0] b);
        logic [WS-1:0] ae [AR][AC];
        logic [WS-1:0] be [BR][BC];
        logic [CW-1:0] c;
        int unsigned   acc;
        c = '0;
        for (int i = 0; i < AR; i++)
            for (int j = 0; j < AC; j++) ae[i][j] = a[(i*AC+j)*WS +: WS];
        for (int i = 0; i < BR; i++)
            for (int j = 0; j < BC; j++) be[i][j] = b[(i*BC+j)*WS +: WS];
        case (op)
            2'b00: for (int i = 0; i < AR; i++)
                       for (int j = 0; j < AC; j++) c[(i*AC+j)*WS +: WS] = ae[i][j] + be[i][j];
            2'b01: for (int i = 0; i < AR; i++)
                       for (int j = 0; j < AC; j++) c[(i*AC+j)*WS +: WS] = ae[i][j] - be[i][j];
            2'b10: for (int i = 0; i < AR; i++)
                       for (int j = 0; j < BC; j++) begin
                           acc = 0;
                           for (int k = 0; k < AC; k++) acc += ae[i][k] * be[k][j];
                           c[(i*BC+j)*WS +: WS] = acc[WS-1:0];
                       end
            default: for (int i = 0; i < AR; i++)
                         for (int j = 0; j < AC; j++)
                             for (int k = 0; k < BR; k++)
                                 for (int l = 0; l < BC; l++)
                                     c[((i*BR+k)*(AC*BC) + (j*BC+l))*WS +: WS] = ae[i][j] * be[k][l];
        endcase
        return c;
    endfunction

    // Stand-in for the shared matrix_alu: one registered cycle of latency.
    always @(posedge clk) alu_C <= alu_ref(alu_op, alu_A, alu_B);

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req0_valid = 1'b0; req0_op = '0; req0_A = '0; req0_B = '0;
        req1_valid = 1'b0; req1_op = '0; req1_A = '0; req1_B = '0;
    endtask

    task automatic drive_req(input logic id, input logic [1:0] op, input logic [AW-1:0] a,
                             input logic [BW-1:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_A = a; req1_B = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_A = a; req0_B = b;
        end
    endtask

    task automatic wait_ready(input logic id);
        int t;
        t = 0;
        #1;
        while (((id ? req1_ready : req0_ready) !== 1'b1) && t < 20) begin
            step();
            t++;
        end
        if (t == 20) fail_now("handshake_timeout");
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        clear_reqs();
        rsp_ready = 1'b1;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req0_ready"}, req0_ready, 0);
        chk({tag, "_req1_ready"}, req1_ready, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_alu_A"}, alu_A, 0);
        chk({tag, "_alu_B"}, alu_B, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_C"}, rsp_C, 0);
        chk({tag, "_perf0"}, perf_cnt0, 0);
        chk({tag, "_perf1"}, perf_cnt1, 0);
    endtask

    function automatic int perf_exp(input int n);
`ifdef MATRIX_ALU_SCHED_PERF_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic run_vec(input vec_t v);
        drive_req(v.id, v.op, v.a, v.b);
        wait_ready(v.id);
        step();
        clear_reqs();
        chk("lat_issue_valid", rsp_valid, 0);
        step();
        chk("lat_wait_valid", rsp_valid, 0);
        step();
        chk("lat_resp_valid", rsp_valid, 1);
        chk("vec_rsp_C", rsp_C, v.c);
        chk("vec_rsp_id", rsp_id, v.id);
        step();
        chk("vec_after_hs_valid", rsp_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            ncap;
        int            tcap [4];
        logic          idcap [4];
        logic [CW-1:0] ccap [4];
        logic          mbusy, mlast, mid, g, er0, er1, erv;
        int            mage, mp0, mp1;
        logic [CW-1:0] mc;

        resetn    = 1'b0;
        rsp_ready = 1'b1;
        clear_reqs();
        step();
        step();
        check_reset_vals("rst_hold");
        resetn = 1'b1;
        step();
        check_reset_vals("rst_release");

        vecs[0] = '{1'b0, 2'b00, 32'h04030201, 32'h08070605, 128'h0C0A0806};
        vecs[1] = '{1'b1, 2'b01, 32'h0A0A0A0A, 32'h04030201, 128'h06070809};
        vecs[2] = '{1'b0, 2'b10, 32'h04030201, 32'h08070605, 128'h322B1613};
        vecs[3] = '{1'b1, 2'b11, 32'h01000001, 32'h04030201,
                    128'h04030000020100000000040300000201};
        vecs[4] = '{1'b0, 2'b01, 32'h00000000, 32'h01010101, 128'hFFFFFFFF};
        vecs[5] = '{1'b1, 2'b00, 32'h80FF7F01, 32'h80010101, 128'h00008002};
        vecs[6] = '{1'b1, 2'b10, 32'h02000002, 32'h06050403, 128'h0C0A0806};
        for (int unsigned i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            if (i == 4) begin
                chk("perf0_after_5", perf_cnt0, perf_exp(3));
                chk("perf1_after_5", perf_cnt1, perf_exp(2));
            end
        end

        // Response backpressure with both requesters waiting.
        rsp_ready = 1'b0;
        drive_req(1'b0, 2'b00, 32'h11223344, 32'h01010101);
        wait_ready(1'b0);
        step();
        drive_req(1'b0, 2'b01, 32'hAAAAAAAA, 32'h00000000);
        drive_req(1'b1, 2'b11, 32'h55555555, 32'h00000000);
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_C", rsp_C, 128'h12233445);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_req0_ready", req0_ready, 0);
            chk("bp_req1_ready", req1_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_req0_ready", req0_ready, 0);
        chk("bp_release_req1_ready", req1_ready, 0);
        step();
        chk("bp_done_valid", rsp_valid, 0);
        chk("bp_next_req1_ready", req1_ready, 1);
        chk("bp_next_req0_ready", req0_ready, 0);
        clear_reqs();
        step();
        step();
        chk("drop_no_rsp", rsp_valid, 0);
        chk("drop_alu_op_kept", alu_op, 2'b00);
        chk("drop_alu_A_kept", alu_A, 32'h11223344);

        // Reset while waiting on the ALU.
        drive_req(1'b1, 2'b11, 32'h01000001, 32'h04030201);
        wait_ready(1'b1);
        step();
        clear_reqs();
        step();
        resetn = 1'b0;
        #1;
        check_reset_vals("rst_wait");
        step();
        resetn = 1'b1;
        step();
        chk("rst_wait_after_valid", rsp_valid, 0);

        // Reset while holding a response: rsp_valid must fall without a clock edge.
        rsp_ready = 1'b0;
        drive_req(1'b0, 2'b00, 32'h01010101, 32'h01010101);
        wait_ready(1'b0);
        step();
        clear_reqs();
        step();
        step();
        chk("rst_resp_pre_valid", rsp_valid, 1);
        resetn = 1'b0;
        #1;
        chk("rst_resp_async_valid", rsp_valid, 0);
        chk("rst_resp_async_C", rsp_C, 0);
        step();
        resetn = 1'b1;
        rsp_ready = 1'b1;

        // Continuous contention: requester 0 first, then strict alternation.
        drive_req(1'b0, 2'b10, 32'h04030201, 32'h08070605);
        drive_req(1'b1, 2'b01, 32'h0A0A0A0A, 32'h04030201);
        #1;
        chk("cont_first_req0_ready", req0_ready, 1);
        chk("cont_first_req1_ready", req1_ready, 0);
        ncap = 0;
        for (int t = 0; t < 40 && ncap < 4; t++) begin
            if (rsp_valid) begin
                tcap[ncap]  = t;
                idcap[ncap] = rsp_id;
                ccap[ncap]  = rsp_C;
                ncap++;
            end
            step();
        end
        if (ncap < 4) begin
            fail_now("contention_count");
        end else begin
            for (int i = 0; i < 4; i++) begin
                chk("cont_id", idcap[i], i % 2);
                chk("cont_C", ccap[i], (i % 2 == 0) ? 128'h322B1613 : 128'h06070809);
                if (i > 0) chk("cont_spacing", tcap[i] - tcap[i-1], 4);
            end
        end

        // Randomized traffic against a transaction-level model.
        apply_reset();
        mbusy = 1'b0; mlast = 1'b1; mid = 1'b0; mage = 0; mp0 = 0; mp1 = 0; mc = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req0_valid = ($urandom_range(0, 99) < 45);
            req1_valid = ($urandom_range(0, 99) < 45);
            req0_op    = 2'($urandom_range(0, 3));
            req1_op    = 2'($urandom_range(0, 3));
            req0_A     = $urandom();
            req0_B     = $urandom();
            req1_A     = $urandom();
            req1_B     = $urandom();
            rsp_ready  = ($urandom_range(0, 99) < 60);
            #1;
            g   = (req0_valid && req1_valid) ? ~mlast : req1_valid;
            er0 = !mbusy && req0_valid && !g;
            er1 = !mbusy && req1_valid && g;
            erv = mbusy && (mage >= 2);
            chk("rnd_req0_ready", req0_ready, er0);
            chk("rnd_req1_ready", req1_ready, er1);
            chk("rnd_rsp_valid", rsp_valid, erv);
            if (erv) begin
                chk("rnd_rsp_id", rsp_id, mid);
                chk("rnd_rsp_C", rsp_C, mc);
            end
            if (er0 || er1) begin
                mbusy = 1'b1;
                mage  = 0;
                mlast = g;
                mid   = g;
                mc    = g ? alu_ref(req1_op, req1_A, req1_B) : alu_ref(req0_op, req0_A, req0_B);
            end else if (mbusy) begin
                if (erv && rsp_ready) begin
                    mbusy = 1'b0;
                    if (mid) mp1++; else mp0++;
                end else if (mage < 2) begin
                    mage++;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("rnd_perf0", perf_cnt0, perf_exp(mp0));
        chk("rnd_perf1", perf_cnt1, perf_exp(mp1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
